// File: rtl/sample_ctrl_pkg.sv
// sample_ctrl_pkg: state encoding and default sizing shared by the capture sequencer files
package sample_ctrl_pkg;
    localparam int DEF_NUM_POINTS     = 64;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_TIMEOUT_CYCLES = 2097152;
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_CAPTURE, S_DRAIN, S_HOLDOFF, S_ERROR} state_t;
endpackage

// File: rtl/capture_frame_buf.sv
// capture_frame_buf: one-frame register file, synchronous write, asynchronous read
module capture_frame_buf
    import sample_ctrl_pkg::*;
#(
    parameter int NUM_POINTS = DEF_NUM_POINTS,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                          clk_100M,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_POINTS)-1:0] wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [$clog2(NUM_POINTS)-1:0] rd_addr,
    output logic [DATA_W-1:0]             rd_data
);
    logic [DATA_W-1:0] mem [NUM_POINTS];
    // One word stored per accepted sampler strobe
    always_ff @(posedge clk_100M) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sample_capture_ctrl.sv
// sample_capture_ctrl: sampler capture sequencer with retry and frame streaming; SAMPLE_CTRL_TIMEOUT_EN enables the capture timeout
module sample_capture_ctrl
    import sample_ctrl_pkg::*;
#(
    parameter int NUM_POINTS     = DEF_NUM_POINTS,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ARM_LOW        = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int RETRY_MAX      = 3,
    parameter int HOLDOFF_CYCLES = 1000
) (
    input  logic              clk_100M,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont_mode,
    input  logic              abort,
    input  logic              err_clr,
    output logic              sampler_en,
    input  logic              sampler_done,
    input  logic [DATA_W-1:0] sampler_data,
    output logic              frm_valid,
    input  logic              frm_ready,
    output logic [DATA_W-1:0] frm_data,
    output logic              frm_last,
    output logic              busy,
    output logic              err_timeout,
    output logic [15:0]       frame_cnt
);
    localparam int PW = $clog2(NUM_POINTS) + 1;
    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam int AW = $clog2(ARM_LOW) + 1;
    localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;

    state_t            state;
    logic [PW-1:0]     wr_idx, rd_idx;
    logic [RW-1:0]     retry_cnt;
    logic [AW-1:0]     arm_cnt;
    logic [HW-1:0]     hold_cnt;
    logic [DATA_W-1:0] rd_word;
    logic              timeout, complete, fail;

`ifdef SAMPLE_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] to_cnt;
    assign timeout = to_cnt == TW'(TIMEOUT_CYCLES - 1);
    // Attempt timer: held at zero outside CAPTURE, counts up and saturates at the limit inside it
    always_ff @(posedge clk_100M) begin
        if (!rst_n || state != S_CAPTURE) to_cnt <= '0;
        else if (!timeout) to_cnt <= to_cnt + 1'b1;
    end
`else
    // No attempt timer: CAPTURE waits for a burst indefinitely
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    assign complete = sampler_done && wr_idx == PW'(NUM_POINTS - 1);
    assign fail     = !complete && (timeout || (!sampler_done && wr_idx != '0));
    assign frm_data = frm_valid ? rd_word : '0;
    assign frm_last = frm_valid && rd_idx == PW'(NUM_POINTS - 1);

    capture_frame_buf #(.NUM_POINTS(NUM_POINTS), .DATA_W(DATA_W)) u_buf (
        .clk_100M (clk_100M),
        .wr_en    (state == S_CAPTURE && sampler_done),
        .wr_addr  (wr_idx[PW-2:0]),
        .wr_data  (sampler_data),
        .rd_addr  (rd_idx[PW-2:0]),
        .rd_data  (rd_word)
    );

    // Sequencer: state, counters and every registered output move together
    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sampler_en  <= 1'b0;
            frm_valid   <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            frame_cnt   <= '0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            retry_cnt   <= '0;
            arm_cnt     <= '0;
            hold_cnt    <= '0;
        end else if (abort && state != S_ERROR) begin
            state      <= S_IDLE;
            sampler_en <= 1'b0;
            frm_valid  <= 1'b0;
            busy       <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start || cont_mode) begin
                        state   <= S_ARM;
                        busy    <= 1'b1;
                        arm_cnt <= '0;
                        wr_idx  <= '0;
                    end
                end
                S_ARM: begin
                    if (arm_cnt == AW'(ARM_LOW - 1)) begin
                        state      <= S_CAPTURE;
                        sampler_en <= 1'b1;
                    end else arm_cnt <= arm_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    if (complete) begin
                        state      <= S_DRAIN;
                        sampler_en <= 1'b0;
                        frm_valid  <= 1'b1;
                        rd_idx     <= '0;
                    end else if (fail) begin
                        sampler_en <= 1'b0;
                        wr_idx     <= '0;
                        arm_cnt    <= '0;
                        if (retry_cnt < RW'(RETRY_MAX)) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= S_ARM;
                        end else begin
                            state       <= S_ERROR;
                            busy        <= 1'b0;
                            err_timeout <= 1'b1;
                        end
                    end else if (sampler_done) wr_idx <= wr_idx + 1'b1;
                end
                S_DRAIN: begin
                    if (frm_ready) begin
                        if (rd_idx == PW'(NUM_POINTS - 1)) begin
                            frm_valid <= 1'b0;
                            frame_cnt <= frame_cnt + 16'd1;
                            retry_cnt <= '0;
                            hold_cnt  <= '0;
                            busy      <= cont_mode;
                            state     <= cont_mode ? S_HOLDOFF : S_IDLE;
                        end else rd_idx <= rd_idx + 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (!cont_mode) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
                        state   <= S_ARM;
                        arm_cnt <= '0;
                        wr_idx  <= '0;
                    end else hold_cnt <= hold_cnt + 1'b1;
                end
                S_ERROR: begin
                    if (err_clr) begin
                        state       <= S_IDLE;
                        err_timeout <= 1'b0;
                        retry_cnt   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
